// File: rtl/tlbfill.sv
// rtl/tlbfill.sv - TLB fill sequencer: PTE screening, victim choice, entry write strobes.
// Optional feature: define TLB_PLRU_EN for tree pseudo-LRU replacement (default round-robin).

package config_pkg;
  localparam int XLEN = 64;
endpackage

module tlbfill
  import config_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter int VPN_BITS    = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   FillValid,
  output logic                   FillReady,
  input  logic [XLEN-1:0]        FillPTE,
  input  logic [VPN_BITS-1:0]    FillVPN,
  input  logic                   LookupValid,
  input  logic [TLB_ENTRIES-1:0] Matches,
  input  logic                   FlushAll,
  output logic [XLEN-1:0]        PTE,
  output logic [VPN_BITS-1:0]    WriteVPN,
  output logic [TLB_ENTRIES-1:0] WriteEnables,
  output logic [TLB_ENTRIES-1:0] EntryValid,
  output logic                   FillDone,
  output logic                   FillError
);

  localparam int IW = $clog2(TLB_ENTRIES);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

  state_t                 state, state_nx;
  logic [TLB_ENTRIES-1:0] valid_r;
  logic [IW-1:0]          victim_r, victim_c, first_inv, policy_victim;
  logic                   accept, malformed, rsvd_bad, all_valid;

  assign accept     = (state == IDLE) && FillValid && !FlushAll;
  assign all_valid  = &valid_r;
  assign EntryValid = valid_r;

  if (XLEN == 64) begin : g_rsvd
    assign rsvd_bad = |PTE[60:54];
  end else begin : g_norsvd
    assign rsvd_bad = 1'b0;
  end

  assign malformed = !PTE[0] || (PTE[2] && !PTE[1]) || rsvd_bad;

  always_comb begin
    first_inv = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (!valid_r[i]) first_inv = IW'(i);
  end

  assign victim_c = all_valid ? policy_victim : first_inv;

`ifdef TLB_PLRU_EN
  logic [TLB_ENTRIES-2:0] tree;
  logic [IW-1:0]          hit_idx;
  logic                   hit_ok;

  // Heap-ordered nodes: node k (1-based) at tree[k-1], children 2k and 2k+1.
  function automatic logic [TLB_ENTRIES-2:0] touch(input logic [TLB_ENTRIES-2:0] t,
                                                   input logic [IW-1:0] idx);
    logic [TLB_ENTRIES-2:0] r;
    int node;
    r    = t;
    node = 1;
    for (int l = IW - 1; l >= 0; l--) begin
      r[node-1] = ~idx[l];
      node      = 2 * node + int'(idx[l]);
    end
    return r;
  endfunction

  assign hit_ok = LookupValid && (Matches != '0) &&
                  ((Matches & (Matches - TLB_ENTRIES'(1))) == '0);

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++)
      if (Matches[i]) hit_idx = IW'(i);
  end

  always_comb begin
    int node;
    node          = 1;
    policy_victim = '0;
    for (int l = IW - 1; l >= 0; l--) begin
      policy_victim[l] = tree[node-1];
      node             = 2 * node + int'(tree[node-1]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         tree <= '0;
    else if (FlushAll) tree <= '0;
    else if (FillDone) tree <= touch(tree, victim_r);
    else if (hit_ok)   tree <= touch(tree, hit_idx);
  end
`else
  logic [IW-1:0] rr_ptr;
  logic          use_ptr_r;
  logic          unused_lookup;

  assign unused_lookup = ^{LookupValid, Matches};
  assign policy_victim = rr_ptr;

  // The pointer only advances when it actually chose the victim.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      use_ptr_r <= 1'b0;
    end else if (FlushAll) begin
      rr_ptr    <= '0;
      use_ptr_r <= 1'b0;
    end else begin
      if (state == CHECK) use_ptr_r <= all_valid;
      if (FillDone && use_ptr_r) rr_ptr <= rr_ptr + IW'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    FillReady    = 1'b0;
    WriteEnables = '0;
    FillDone     = 1'b0;
    FillError    = 1'b0;
    case (state)
      IDLE: begin
        FillReady = !FlushAll;
        if (accept) state_nx = CHECK;
      end
      CHECK: begin
        if (FlushAll) begin
          state_nx = IDLE;
        end else if (malformed) begin
          FillError = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        state_nx = IDLE;
        if (!FlushAll) begin
          WriteEnables = TLB_ENTRIES'(1) << victim_r;
          FillDone     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PTE      <= '0;
      WriteVPN <= '0;
      victim_r <= '0;
    end else begin
      if (accept) begin
        PTE      <= FillPTE;
        WriteVPN <= FillVPN;
      end
      if (state == CHECK) victim_r <= victim_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         valid_r <= '0;
    else if (FlushAll) valid_r <= '0;
    else if (FillDone) valid_r[victim_r] <= 1'b1;
  end

endmodule

// File: tb/tb_tlbfill.sv
// tb/tb_tlbfill.sv - randomized self-checking bench for tlbfill against a transaction-level model.
module tb_tlbfill;
  localparam int N  = 8;
  localparam int VB = 27;
  localparam int XL = config_pkg::XLEN;

  logic          clk = 1'b0;
  logic          reset;
  logic          FillValid, FillReady;
  logic [XL-1:0] FillPTE;
  logic [VB-1:0] FillVPN;
  logic          LookupValid;
  logic [N-1:0]  Matches;
  logic          FlushAll;
  logic [XL-1:0] PTE;
  logic [VB-1:0] WriteVPN;
  logic [N-1:0]  WriteEnables, EntryValid;
  logic          FillDone, FillError;

  always #5 clk = ~clk;

  tlbfill #(.TLB_ENTRIES(N), .VPN_BITS(VB)) dut (
    .clk(clk), .reset(reset), .FillValid(FillValid), .FillReady(FillReady),
    .FillPTE(FillPTE), .FillVPN(FillVPN), .LookupValid(LookupValid), .Matches(Matches),
    .FlushAll(FlushAll), .PTE(PTE), .WriteVPN(WriteVPN), .WriteEnables(WriteEnables),
    .EntryValid(EntryValid), .FillDone(FillDone), .FillError(FillError)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which entries hold translations and the replacement bookkeeping.
  bit [N-1:0] mv;
  int         rrp;
`ifdef TLB_PLRU_EN
  bit         tr[1:N-1];
`endif

  function automatic void model_clear();
    mv  = '0;
    rrp = 0;
`ifdef TLB_PLRU_EN
    for (int k = 1; k < N; k++) tr[k] = 1'b0;
`endif
  endfunction

  function automatic int model_victim();
    for (int i = 0; i < N; i++) if (!mv[i]) return i;
`ifdef TLB_PLRU_EN
    begin
      int n;
      n = 1;
      while (n < N) n = 2 * n + int'(tr[n]);
      return n - N;
    end
`else
    return rrp;
`endif
  endfunction

`ifdef TLB_PLRU_EN
  // Walk from leaf to root; each ancestor is turned towards the other subtree.
  function automatic void model_touch(input int i);
    int n, p;
    n = i + N;
    while (n > 1) begin
      p     = n / 2;
      tr[p] = (n == 2 * p);
      n     = p;
    end
  endfunction
`endif

  function automatic void model_lookup();
`ifdef TLB_PLRU_EN
    if (LookupValid && $countones(Matches) == 1)
      for (int i = 0; i < N; i++) if (Matches[i]) model_touch(i);
`endif
  endfunction

  function automatic bit model_bad(input logic [63:0] p);
    logic [63:0] q;
    q = p;
    return !q[0] || (q[2] && !q[1]) || (q[60:54] != 7'd0);
  endfunction

  task automatic drive_lookup();
    LookupValid = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 2) != 0) Matches = N'(1) << $urandom_range(0, N - 1);
    else                           Matches = N'($urandom);
  endtask

  // fl: -1 no flush, 1 flush during CHECK, 2 flush during WRITE.
  task automatic fill(input logic [63:0] pte, input logic [VB-1:0] vpn, input int fl);
    int v;
    bit bad, used;
    @(negedge clk);
    FillValid = 1'b1; FillPTE = pte; FillVPN = vpn; FlushAll = 1'b0; drive_lookup();
    #1;
    check("ready_idle", 64'(FillReady), 64'd1);
    model_lookup();

    @(negedge clk);
    FillValid = 1'b0; FillPTE = {$urandom, $urandom}; FillVPN = VB'($urandom);
    FlushAll = (fl == 1); drive_lookup();
    #1;
    bad = model_bad(pte);
    check("check_error", 64'(FillError), 64'(!FlushAll && bad));
    check("check_we", 64'(WriteEnables), 64'd0);
    check("check_ready", 64'(FillReady), 64'd0);
    check("pte_capture", PTE, pte);
    check("vpn_capture", 64'(WriteVPN), 64'(vpn));
    v    = model_victim();
    used = &mv;
    if (fl == 1) model_clear();
    else         model_lookup();

    if (fl != 1 && !bad) begin
      @(negedge clk);
      FlushAll = (fl == 2); drive_lookup();
      #1;
      check("write_we", 64'(WriteEnables), (fl == 2) ? 64'd0 : (64'd1 << v));
      check("write_done", 64'(FillDone), 64'(fl != 2));
      check("write_ready", 64'(FillReady), 64'd0);
      check("write_err", 64'(FillError), 64'd0);
      if (fl == 2) model_clear();
      else begin
        mv[v] = 1'b1;
`ifdef TLB_PLRU_EN
        model_touch(v);
`else
        if (used) rrp = (rrp + 1) % N;
`endif
      end
    end

    @(negedge clk);
    FlushAll = 1'b0; LookupValid = 1'b0; Matches = '0;
    #1;
    check("after_ready", 64'(FillReady), 64'd1);
    check("after_valid", 64'(EntryValid), 64'(mv));
    check("after_we", 64'(WriteEnables), 64'd0);
  endtask

  function automatic logic [63:0] rand_pte();
    logic [63:0] p;
    p = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) begin
      p[0] = 1'b1;
      p[1] = 1'b1;
      p[60:54] = 7'd0;
    end
    return p;
  endfunction

  initial begin
    reset = 1'b1; FillValid = 1'b0; FillPTE = '0; FillVPN = '0;
    LookupValid = 1'b0; Matches = '0; FlushAll = 1'b0;
    model_clear();
    #3;
    check("rst_ready", 64'(FillReady), 64'd1);
    check("rst_we", 64'(WriteEnables), 64'd0);
    check("rst_valid", 64'(EntryValid), 64'd0);
    check("rst_pte", PTE, 64'd0);
    check("rst_vpn", 64'(WriteVPN), 64'd0);
    check("rst_done_err", 64'({FillDone, FillError}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < N; i++) fill(64'hCF, VB'(i), -1);
    check("full_valid", 64'(EntryValid), 64'hFF);
    for (int i = 0; i < N + 1; i++) fill(64'hCF, VB'(100 + i), -1);

    fill(64'h4, VB'($urandom), -1);
    fill(64'h5, VB'($urandom), -1);
    check("bad_keeps_valid", 64'(EntryValid), 64'hFF);

    fill(64'hCF, VB'($urandom), 2);
    check("flush_write_valid", 64'(EntryValid), 64'd0);
    for (int i = 0; i < 3; i++) fill(rand_pte(), VB'($urandom), -1);
    fill(64'hCF, VB'($urandom), 1);

    @(negedge clk);
    FillValid = 1'b1; FillPTE = 64'hCF; FlushAll = 1'b1;
    #1;
    check("flush_idle_ready", 64'(FillReady), 64'd0);
    model_clear();
    @(negedge clk);
    FillValid = 1'b0; FlushAll = 1'b0;
    #1;
    check("flush_idle_valid", 64'(EntryValid), 64'd0);
    check("flush_idle_ready2", 64'(FillReady), 64'd1);

    for (int i = 0; i < 4; i++) fill(64'hCF, VB'($urandom), -1);
    @(negedge clk);
    FillValid = 1'b1; FillPTE = 64'hCF; FillVPN = VB'(7);
    @(negedge clk);
    FillValid = 1'b0;
    #1;
    check("midcheck_ready", 64'(FillReady), 64'd0);
    #1 reset = 1'b1;
    #1;
    check("arst_ready", 64'(FillReady), 64'd1);
    check("arst_valid", 64'(EntryValid), 64'd0);
    check("arst_pte", PTE, 64'd0);
    check("arst_vpn", 64'(WriteVPN), 64'd0);
    check("arst_outs", 64'({WriteEnables, FillDone, FillError}), 64'd0);
    #1 reset = 1'b0;
    model_clear();
    fill(64'hCF, VB'(9), -1);
    check("arst_first_entry", 64'(EntryValid), 64'h01);

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 11);
      fill(rand_pte(), VB'($urandom), (r == 1 || r == 2) ? r : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlbfill.md
# tlbfill

Fill sequencer directly upstream of the TLB entry RAM and CAM. It accepts a completed page-table entry from the hardware page-table walker over a valid/ready handshake and screens out malformed PTEs. It then picks a victim entry and drives a one-cycle one-hot write strobe plus the PTE and VPN into the TLB storage. It also owns the per-entry valid bits and the replacement state, and clears them on a global flush.

## Interface
- TLB_ENTRIES, 8, number of TLB entries; power of two, ≥2
- VPN_BITS, 27, width of the virtual page number tag written to the CAM
- XLEN comes from config_pkg.
- clk  in  1  clock
- reset  in  1  reset; one clock, reset asynchronous and active-high
- FillValid  in  1  walker presents a PTE
- FillReady  out  1  block can accept a fill
- FillPTE  in  XLEN  leaf PTE from the walker
- FillVPN  in  VPN_BITS  VPN being translated
- LookupValid  in  1  a translation lookup is occurring this cycle
- Matches  in  TLB_ENTRIES  per-entry hit vector of that lookup
- FlushAll  in  1  sfence.vma / satp write; invalidate all entries
- PTE  out  XLEN  registered PTE to TLB RAM
- WriteVPN  out  VPN_BITS  registered VPN to TLB CAM
- WriteEnables  out  TLB_ENTRIES  one-hot write strobe; zero when not writing
- EntryValid  out  TLB_ENTRIES  per-entry valid bits
- FillDone  out  1  single-cycle pulse; the entry is written this cycle
- FillError  out  1  single-cycle pulse; the fill was rejected

## Operation
- FSM states: IDLE, CHECK, WRITE.
- IDLE:
  - FillReady = !FlushAll.
  - On FillValid & FillReady, capture FillPTE into PTE and FillVPN into WriteVPN, then go to CHECK.
- CHECK: the PTE is malformed if any of the following holds:
  - PTE[0]=0 (V clear).
  - PTE[2]=1 & PTE[1]=0 (W without R).
  - XLEN=64 and PTE[60:54]≠0.
- Malformed in CHECK: FillError=1 for this cycle, no write, next state IDLE.
- Well-formed in CHECK: latch the victim index, then go to WRITE.
- Victim selection:
  - If any entry is invalid, the victim is the lowest-index invalid entry.
  - Otherwise the victim comes from the replacement policy (see Configuration).
- WRITE:
  - WriteEnables = onehot(victim) and FillDone=1.
  - At the clock edge, set EntryValid[victim] and update the replacement state.
  - Next state IDLE.
- FlushAll:
  - At the next edge, EntryValid clears to 0 and the replacement state resets.
  - In CHECK or WRITE it aborts the fill: WriteEnables=0, FillDone=0, FillError=0, next state IDLE.
  - Flush beats a same-cycle write.
- PTE and WriteVPN keep their values until the next accepted fill.
- Lookup hits with a non-one-hot Matches, or with LookupValid=0, are ignored by the replacement state.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - PTE=0, WriteVPN=0, EntryValid=0, replacement state=0, round-robin pointer=0.
  - WriteEnables=0, FillDone=0, FillError=0.
  - FillReady=1 unless FlushAll is asserted.
- Accept edge at cycle N. CHECK occupies cycle N+1. WRITE occupies cycle N+2.
- The TLB RAM captures PTE at the end of N+2. EntryValid reflects the new entry from N+3.
- A rejected fill pulses FillError in N+1. FillReady returns to 1 in N+2.
- Throughput: one fill per 3 cycles. FillReady=0 in CHECK and WRITE.
- Walker contract: FillPTE and FillVPN must be stable while FillValid=1 and FillReady=0.
- Replacement state update priority within one edge: flush, then write, then lookup hit.

## Configuration
- TLB_PLRU_EN defined:
  - Tree pseudo-LRU with TLB_ENTRIES-1 bits.
  - On a qualified lookup hit, or on a write to entry i, each tree node on i's path points away from i.
  - The victim is found by following the node bits from the root (bit=0 → left/lower half).
- TLB_PLRU_EN undefined:
  - log2(TLB_ENTRIES)-bit round-robin pointer.
  - The victim is the pointer value when all entries are valid.
  - The pointer increments modulo TLB_ENTRIES only after a write that used it (7→0 wraps).
  - Lookup hits have no effect.

## Test plan
- Reset, then 8 well-formed fills (PTE=0x...CF, VPN 0..7) → WriteEnables 0x01,0x02,…,0x80, each in the third cycle after accept; EntryValid=0xFF.
- With the TLB full and TLB_PLRU_EN undefined, 9 more fills → victims 0,1,…,7,0; the pointer wraps.
- With TLB_PLRU_EN: fill all 8, then lookup hits on entries 0 and 4 → the next victim is neither 0 nor 4 (expected 2), matching the tree model.
- Fill with PTE=0x4 (V=0), then PTE=0x5 (W without R) → FillError pulse in N+1 each time, WriteEnables stays 0, EntryValid unchanged.
- FlushAll asserted during WRITE → WriteEnables=0, FillDone=0, EntryValid=0 next cycle, FillReady=0 while FlushAll is high.
- Assert reset asynchronously mid-CHECK → all outputs are at their reset values before the next clock edge; the next fill writes entry 0.
